mm_instr_dispatch: RTL and testbench

- Upstream stage of the matrix-multiply top: buffers 128-bit MM instructions from the instruction fetch/decode path in a small FIFO.
- Screens each instruction's buffer-select fields and issues legal ones one at a time to the MM engine.
- Holds the issued instruction stable until the MM engine reports done.
- Provides busy/level/retire/error status for the controller.

---
 rtl/mm_instr_dispatch.sv | 204 ++++++++++++++++++++
 tb/tb_mm_instr_dispatch.sv | 306 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mm_instr_dispatch.sv
// -----------------------------------------------------------------------------
// mm_instr_dispatch
//
// Upstream stage of the matrix-multiply top. Instructions from fetch/decode
// are queued in a small FIFO. The head is screened for legal buffer selects.
// Illegal instructions are dropped and counted. Each legal instruction is
// issued to the MM engine with a one-cycle start pulse. The issued
// instruction is then held stable until the engine reports done.
//
// Handshake semantics:
//   instr_in is accepted on every rising edge where instr_in_valid and
//   instr_in_ready are both high. instr_in_ready is a registered copy of
//   (level < FIFO_DEPTH), so it never depends combinationally on valid.
//   valid_to_mm and done_from_mm are single-cycle pulses, not a
//   valid/ready pair.
//
// Ports:
//   ap_clk, areset          clock, asynchronous active-low reset
//   instr_in*               instruction push interface from fetch
//   instruction_to_mm       held instruction word for the MM engine
//   valid_to_mm             start pulse (one cycle, in ISSUE)
//   done_from_mm            completion pulse from the MM engine
//   busy, fifo_level        occupancy status
//   retired/illegal_count   wrapping event counters
//   err_illegal/spurious/timeout  sticky flags, cleared by err_clear
//   dbg_state               current FSM state (0 IDLE, 1 ISSUE, 2 BUSY)
// -----------------------------------------------------------------------------
module mm_instr_dispatch #(
    parameter int FIFO_DEPTH     = 4,
    parameter int LVL_W          = 3,
    parameter int CNT_W          = 32,
    parameter int TIMEOUT_CYCLES = 1048576
) (
    input  logic             ap_clk,
    input  logic             areset,
    input  logic [127:0]     instr_in,
    input  logic             instr_in_valid,
    output logic             instr_in_ready,
    output logic [127:0]     instruction_to_mm,
    output logic             valid_to_mm,
    input  logic             done_from_mm,
    output logic             busy,
    output logic [LVL_W-1:0] fifo_level,
    output logic [CNT_W-1:0] retired_count,
    output logic [CNT_W-1:0] illegal_count,
    output logic             err_illegal,
    output logic             err_spurious,
    output logic             err_timeout,
    input  logic             err_clear,
    output logic [1:0]       dbg_state
);

    localparam int PTR_W = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
    localparam int WD_W  = $clog2(TIMEOUT_CYCLES + 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_BUSY  = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [127:0]       mem_q [FIFO_DEPTH];
    logic [PTR_W-1:0]   wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0]   rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0]   level_q, level_d;
    logic               ready_q, ready_d;
    logic [127:0]       instr_q, instr_d;
    logic               settle_q, settle_d;
    logic [WD_W-1:0]    wd_q, wd_d;
    logic [CNT_W-1:0]   retired_q, retired_d;
    logic [CNT_W-1:0]   illegal_q, illegal_d;
    logic               err_ill_q, err_ill_d;
    logic               err_spur_q, err_spur_d;
    logic               err_to_q, err_to_d;

    logic               push, pop;
    logic [127:0]       head;
    logic               head_legal;
    logic               set_illegal, set_spurious, set_timeout;

    assign push = instr_in_valid && ready_q;
    assign head = mem_q[rd_ptr_q];

    // Input select must be one-hot; output select may only target buffer 2 or 3.
    assign head_legal = $onehot(head[4:1]) &&
                        ((head[10:7] == 4'b0100) || (head[10:7] == 4'b1000));

    // settle_q blocks the pop in the first IDLE cycle after done, so the engine
    // sees the previous instruction for one full IDLE cycle before a reload.
    assign pop = (state_q == S_IDLE) && !settle_q && (level_q != '0);

    assign set_spurious = done_from_mm && (state_q != S_BUSY);
    assign set_timeout  = (state_q == S_BUSY) && (wd_q == WD_W'(TIMEOUT_CYCLES - 1));

    always_comb begin
        state_d     = state_q;
        instr_d     = instr_q;
        settle_d    = 1'b0;
        wd_d        = '0;
        retired_d   = retired_q;
        illegal_d   = illegal_q;
        set_illegal = 1'b0;
        case (state_q)
            S_IDLE: begin
                if (pop) begin
                    if (head_legal) begin
                        instr_d = head;
                        state_d = S_ISSUE;
                    end else begin
                        illegal_d   = illegal_q + CNT_W'(1);
                        set_illegal = 1'b1;
                    end
                end
            end
            S_ISSUE: begin
                state_d = S_BUSY;
            end
            S_BUSY: begin
                if (done_from_mm) begin
                    retired_d = retired_q + CNT_W'(1);
                    settle_d  = 1'b1;
                    state_d   = S_IDLE;
                end else if (wd_q != WD_W'(TIMEOUT_CYCLES)) begin
                    // Saturates so a long stall flags the timeout only once.
                    wd_d = wd_q + WD_W'(1);
                end else begin
                    wd_d = wd_q;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_comb begin
        wr_ptr_d = push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
        rd_ptr_d = pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;
        level_d  = level_q;
        case ({push, pop})
            2'b10:   level_d = level_q + LVL_W'(1);
            2'b01:   level_d = level_q - LVL_W'(1);
            default: level_d = level_q;
        endcase
        ready_d = (level_d < LVL_W'(FIFO_DEPTH));
    end

    // A setting event in the same cycle as err_clear wins.
    assign err_ill_d  = set_illegal  || (err_ill_q  && !err_clear);
    assign err_spur_d = set_spurious || (err_spur_q && !err_clear);
    assign err_to_d   = set_timeout  || (err_to_q   && !err_clear);

    always_ff @(posedge ap_clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= instr_in;
        end
    end

    always_ff @(posedge ap_clk or negedge areset) begin
        if (!areset) begin
            state_q    <= S_IDLE;
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            level_q    <= '0;
            ready_q    <= 1'b0;
            instr_q    <= '0;
            settle_q   <= 1'b0;
            wd_q       <= '0;
            retired_q  <= '0;
            illegal_q  <= '0;
            err_ill_q  <= 1'b0;
            err_spur_q <= 1'b0;
            err_to_q   <= 1'b0;
        end else begin
            state_q    <= state_d;
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            level_q    <= level_d;
            ready_q    <= ready_d;
            instr_q    <= instr_d;
            settle_q   <= settle_d;
            wd_q       <= wd_d;
            retired_q  <= retired_d;
            illegal_q  <= illegal_d;
            err_ill_q  <= err_ill_d;
            err_spur_q <= err_spur_d;
            err_to_q   <= err_to_d;
        end
    end

    assign instr_in_ready    = ready_q;
    assign instruction_to_mm = instr_q;
    assign valid_to_mm       = (state_q == S_ISSUE);
    assign busy              = (state_q != S_IDLE) || (level_q != '0);
    assign fifo_level        = level_q;
    assign retired_count     = retired_q;
    assign illegal_count     = illegal_q;
    assign err_illegal       = err_ill_q;
    assign err_spurious      = err_spur_q;
    assign err_timeout       = err_to_q;
    assign dbg_state         = state_q;

endmodule

// File: tb/tb_mm_instr_dispatch.sv
module tb_mm_instr_dispatch;

    localparam int LVL_W = 3;
    localparam int CNT_W = 32;

    // clock / reset
    logic ap_clk = 1'b0;
    logic areset = 1'b0;
    always #5 ap_clk = ~ap_clk;

    logic [127:0]     instr_in = '0;
    logic             instr_in_valid = 1'b0;
    logic             instr_in_ready;
    logic [127:0]     instruction_to_mm;
    logic             valid_to_mm;
    logic             done_from_mm = 1'b0;
    logic             busy;
    logic [LVL_W-1:0] fifo_level;
    logic [CNT_W-1:0] retired_count;
    logic [CNT_W-1:0] illegal_count;
    logic             err_illegal;
    logic             err_spurious;
    logic             err_timeout;
    logic             err_clear = 1'b0;
    logic [1:0]       dbg_state;

    mm_instr_dispatch #(
        .FIFO_DEPTH     (4),
        .LVL_W          (LVL_W),
        .CNT_W          (CNT_W),
        .TIMEOUT_CYCLES (16)
    ) dut (
        .ap_clk            (ap_clk),
        .areset            (areset),
        .instr_in          (instr_in),
        .instr_in_valid    (instr_in_valid),
        .instr_in_ready    (instr_in_ready),
        .instruction_to_mm (instruction_to_mm),
        .valid_to_mm       (valid_to_mm),
        .done_from_mm      (done_from_mm),
        .busy              (busy),
        .fifo_level        (fifo_level),
        .retired_count     (retired_count),
        .illegal_count     (illegal_count),
        .err_illegal       (err_illegal),
        .err_spurious      (err_spurious),
        .err_timeout       (err_timeout),
        .err_clear         (err_clear),
        .dbg_state         (dbg_state)
    );

    // scoreboard state
    logic [127:0] exp_q[$];
    int n_checks = 0;
    int n_pass   = 0;
    int n_issued = 0;
    int cyc      = 0;
    int last_done = 0;
    bit seen_done = 0;
    bit auto_en   = 0;
    int auto_delay = 3;

    task automatic check(input string tag, input logic [127:0] got, input logic [127:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic tick();
        @(posedge ap_clk);
        #1;
    endtask

    function automatic logic [127:0] mk(input logic [3:0] insel, input logic [3:0] outsel,
                                         input logic [7:0] tag);
        logic [127:0] r;
        r = {16{tag}};
        r[4:1]  = insel;
        r[10:7] = outsel;
        return r;
    endfunction

    task automatic push_instr(input logic [127:0] d, input bit legal);
        int n;
        n = 0;
        instr_in = d;
        instr_in_valid = 1'b1;
        while (!instr_in_ready && n < 200) begin
            tick();
            n++;
        end
        check("push_ready_wait", 128'(instr_in_ready), 128'(1));
        if (legal) exp_q.push_back(d);
        tick();
        instr_in_valid = 1'b0;
    endtask

    task automatic wait_retired(input int target);
        int n;
        n = 0;
        while (retired_count != CNT_W'(target) && n < 600) begin
            tick();
            n++;
        end
        check("retired_count", 128'(retired_count), 128'(target));
    endtask

    // issue monitor: compares every start pulse against the expected queue
    initial begin
        forever begin
            @(negedge ap_clk);
            cyc++;
            if (done_from_mm) begin
                last_done = cyc;
                seen_done = 1;
            end
            if (valid_to_mm) begin
                n_issued++;
                if (exp_q.size() == 0) begin
                    check("unexpected_issue", 128'(1), 128'(0));
                end else begin
                    check("issue_order", instruction_to_mm, exp_q.pop_front());
                end
                if (seen_done) check("issue_gap_after_done", 128'(cyc - last_done >= 3), 128'(1));
            end
        end
    end

    // automatic MM engine responder
    initial begin
        forever begin
            tick();
            if (auto_en && valid_to_mm) begin
                repeat (auto_delay) tick();
                done_from_mm = 1'b1;
                tick();
                done_from_mm = 1'b0;
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: got stuck expected finish");
        $fatal(1, "global timeout");
    end

    initial begin
        logic [127:0] i1;
        logic [127:0] la, lb, xa, xb;
        int base;

        // reset state
        #2;
        check("rst_ready", 128'(instr_in_ready), 128'(0));
        check("rst_valid", 128'(valid_to_mm), 128'(0));
        check("rst_instr", instruction_to_mm, 128'(0));
        check("rst_level", 128'(fifo_level), 128'(0));
        check("rst_busy", 128'(busy), 128'(0));
        tick(); tick();
        areset = 1'b1;
        tick(); tick();
        check("ready_after_rst", 128'(instr_in_ready), 128'(1));

        // single legal instruction, manual done at cycle 10
        i1 = mk(4'b0001, 4'b0100, 8'hA1);
        push_instr(i1, 1);                       // now cycle 1
        check("t1_level_c1", 128'(fifo_level), 128'(1));
        check("t1_valid_c1", 128'(valid_to_mm), 128'(0));
        tick();                                  // cycle 2
        check("t1_valid_c2", 128'(valid_to_mm), 128'(1));
        check("t1_instr_c2", instruction_to_mm, i1);
        for (int c = 3; c <= 10; c++) begin
            tick();
            check("t1_valid_low", 128'(valid_to_mm), 128'(0));
            check("t1_instr_hold", instruction_to_mm, i1);
        end
        check("t1_state_busy", 128'(dbg_state), 128'(2));
        done_from_mm = 1'b1;                     // cycle 10
        tick();                                  // cycle 11
        done_from_mm = 1'b0;
        check("t1_busy_c11", 128'(busy), 128'(0));
        check("t1_retired", 128'(retired_count), 128'(1));
        check("t1_state_idle", 128'(dbg_state), 128'(0));
        check("t1_instr_kept", instruction_to_mm, i1);
        repeat (3) tick();

        // five back-to-back pushes, done 20 cycles after each start
        auto_delay = 20;
        auto_en = 1;
        base = n_issued;
        for (int k = 0; k < 5; k++) begin
            push_instr(mk(4'b0001 << (k % 4), (k % 2) ? 4'b1000 : 4'b0100, 8'(8'h10 + k)), 1);
        end
        check("t2_ready_full", 128'(instr_in_ready), 128'(0));
        check("t2_level_full", 128'(fifo_level), 128'(4));
        wait_retired(6);
        check("t2_issued", 128'(n_issued - base), 128'(5));
        check("t2_queue_empty", 128'(exp_q.size()), 128'(0));
        check("t2_busy_end", 128'(busy), 128'(0));

        // illegal instructions between legal ones
        auto_delay = 3;
        la = mk(4'b0010, 4'b0100, 8'h21);
        xa = mk(4'b0011, 4'b0100, 8'h22);        // input select not one-hot
        xb = mk(4'b0100, 4'b0010, 8'h23);        // output select not 0100/1000
        lb = mk(4'b1000, 4'b1000, 8'h24);
        push_instr(la, 1);
        push_instr(xa, 0);
        push_instr(xb, 0);
        push_instr(lb, 1);
        wait_retired(8);
        repeat (3) tick();
        check("t3_illegal_count", 128'(illegal_count), 128'(2));
        check("t3_err_illegal", 128'(err_illegal), 128'(1));
        check("t3_queue_empty", 128'(exp_q.size()), 128'(0));
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check("t3_err_cleared", 128'(err_illegal), 128'(0));
        check("t3_illegal_kept", 128'(illegal_count), 128'(2));

        // spurious done while idle
        auto_en = 0;
        done_from_mm = 1'b1;
        tick();
        done_from_mm = 1'b0;
        check("t4_err_spurious", 128'(err_spurious), 128'(1));
        check("t4_retired_same", 128'(retired_count), 128'(8));
        check("t4_state_idle", 128'(dbg_state), 128'(0));
        done_from_mm = 1'b1;                     // set coinciding with clear
        err_clear = 1'b1;
        tick();
        done_from_mm = 1'b0;
        err_clear = 1'b0;
        check("t4_set_beats_clear", 128'(err_spurious), 128'(1));
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check("t4_err_cleared", 128'(err_spurious), 128'(0));
        auto_en = 1;
        push_instr(mk(4'b0100, 4'b1000, 8'h31), 1);
        wait_retired(9);
        auto_en = 0;
        repeat (5) tick();

        // watchdog timeout with done withheld
        push_instr(mk(4'b0001, 4'b0100, 8'h41), 1); // cycle 1
        tick();                                     // cycle 2
        check("t5_issue", 128'(dbg_state), 128'(1));
        tick();                                     // cycle 3, first BUSY cycle
        repeat (15) tick();                         // cycle 18
        check("t5_no_timeout_yet", 128'(err_timeout), 128'(0));
        tick();                                     // cycle 19
        check("t5_timeout", 128'(err_timeout), 128'(1));
        check("t5_still_busy", 128'(dbg_state), 128'(2));
        repeat (10) tick();
        check("t5_busy_later", 128'(dbg_state), 128'(2));
        done_from_mm = 1'b1;
        tick();
        done_from_mm = 1'b0;
        check("t5_idle_after_done", 128'(dbg_state), 128'(0));
        check("t5_retired", 128'(retired_count), 128'(10));
        check("t5_timeout_sticky", 128'(err_timeout), 128'(1));
        err_clear = 1'b1;
        tick();
        err_clear = 1'b0;
        check("t5_timeout_cleared", 128'(err_timeout), 128'(0));
        repeat (3) tick();

        // reset while busy with two queued
        push_instr(mk(4'b0010, 4'b1000, 8'h51), 1);
        tick(); tick();
        push_instr(mk(4'b0001, 4'b0100, 8'h52), 1);
        push_instr(mk(4'b0100, 4'b0100, 8'h53), 1);
        check("t6_level2", 128'(fifo_level), 128'(2));
        check("t6_busy_state", 128'(dbg_state), 128'(2));
        areset = 1'b0;
        #1;
        check("t6_rst_valid", 128'(valid_to_mm), 128'(0));
        check("t6_rst_instr", instruction_to_mm, 128'(0));
        check("t6_rst_level", 128'(fifo_level), 128'(0));
        check("t6_rst_ready", 128'(instr_in_ready), 128'(0));
        check("t6_rst_busy", 128'(busy), 128'(0));
        check("t6_rst_retired", 128'(retired_count), 128'(0));
        check("t6_rst_illegal", 128'(illegal_count), 128'(0));
        exp_q.delete();
        tick(); tick();
        areset = 1'b1;
        repeat (6) tick();
        check("t6_post_level", 128'(fifo_level), 128'(0));
        check("t6_post_busy", 128'(busy), 128'(0));
        check("t6_post_state", 128'(dbg_state), 128'(0));
        check("t6_post_ready", 128'(instr_in_ready), 128'(1));
        auto_delay = 2;
        auto_en = 1;
        push_instr(mk(4'b1000, 4'b0100, 8'h61), 1);
        wait_retired(1);
        check("t6_queue_empty", 128'(exp_q.size()), 128'(0));
        repeat (4) tick();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
